// File: rtl/sample_feeder_if.sv
// Four-phase request/acknowledge port between the filter (initiator) and the
// sample feeder (responder).
interface sample_feeder_if #(
    parameter int DDWIDTH = 32
);
    logic               in_req;
    logic               in_ack;
    logic [DDWIDTH-1:0] in_data;

    modport master (output in_req, input in_ack, input in_data);
    modport slave  (input in_req, output in_ack, output in_data);
endinterface

// File: rtl/sample_feeder.sv
// Buffers upstream samples in a circular FIFO and hands one sign-extended word
// to the filter per four-phase handshake.
module sample_feeder #(
    parameter int DWIDTH  = 16,
    parameter int DDWIDTH = 32,
    parameter int DEPTH   = 16,
    parameter int AWIDTH  = 4,
    parameter int CNTW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DWIDTH-1:0]   wr_data,
    input  logic                flush,
    sample_feeder_if.slave      in_port,
    output logic                full,
    output logic                empty,
    output logic [AWIDTH:0]     level,
    output logic [CNTW-1:0]     underrun_cnt,
    output logic [CNTW-1:0]     overflow_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [AWIDTH:0] FULL_LEVEL = (AWIDTH+1)'(DEPTH);

    state_t            state, state_next;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    logic [AWIDTH:0]   level_next;
    logic [DWIDTH-1:0] head;
    logic              pop, count_underrun, wr_accept, wr_drop;

    assign head           = mem[rd_ptr];
    assign in_port.in_ack = (state == ACK);

    // A full FIFO still accepts a write when the same cycle pops; flush discards it silently.
    assign wr_accept = wr_en && !flush && (!full || pop);
    assign wr_drop   = wr_en && !flush && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Pops are suppressed during flush so the clear never races a read.
    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        count_underrun = 1'b0;
        case (state)
            IDLE: begin
                if (in_req_seen()) begin
                    if (!empty && !flush) begin
                        pop        = 1'b1;
                        state_next = ACK;
                    end else if (empty) begin
                        count_underrun = 1'b1;
                        state_next     = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!in_port.in_req) begin
                    state_next = IDLE;
                end else if (!empty && !flush) begin
                    pop        = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!in_port.in_req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    function automatic logic in_req_seen();
        return in_port.in_req;
    endfunction

    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else begin
            case ({wr_accept, pop})
                2'b10:   level_next = level + 1'b1;
                2'b01:   level_next = level - 1'b1;
                default: level_next = level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            full            <= 1'b0;
            empty           <= 1'b1;
            in_port.in_data <= '0;
            underrun_cnt    <= '0;
            overflow_cnt    <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
                if (pop)       rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            full  <= (level_next == FULL_LEVEL);
            empty <= (level_next == '0);
            if (pop) in_port.in_data <= {{(DDWIDTH-DWIDTH){head[DWIDTH-1]}}, head};
            if (count_underrun && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
            if (wr_drop && (overflow_cnt != '1))        overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

endmodule
